sram_bridge: RTL and testbench
==============================

# sram_bridge

Bridges 32-bit data-memory accesses from the DLX processor to the 16-bit external SRAM (ce_n/we_n/oe_n/ub_n/lb_n interface, synchronous read). Each 32-bit access becomes a low-half then high-half SRAM access, with byte enables mapped to lb_n/ub_n. The block is the initiator for the single-port SRAM model, which acts as responder, and sits between the processor data port and the SRAM pins in `top`.

## Interface
- DATA_WIDTH, 32, host data width; fixed at 2×SRAM_DATA_WIDTH
- SRAM_DATA_WIDTH, 16, SRAM data width
- SRAM_ADDR_WIDTH, 10, SRAM half-word address width; host word address is SRAM_ADDR_WIDTH-1 bits
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_rd  in  1  read request; sampled only when req_ready=1
- req_wr  in  1  write request; sampled only when req_ready=1
- req_addr  in  SRAM_ADDR_WIDTH-1  word address
- req_be  in  4  byte enables for writes; bit i covers req_wdata[8i+7:8i]
- req_wdata  in  DATA_WIDTH  write data
- req_ready  out  1  high when idle; combinational from state
- rsp_valid  out  1  one-cycle completion pulse for reads and writes
- rsp_rdata  out  DATA_WIDTH  read data {hi,lo}; held until next read completes
- sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM controls
- sram_addr  out  SRAM_ADDR_WIDTH  half-word address
- sram_wr_data  out  SRAM_DATA_WIDTH  write data
- sram_rd_data  in  SRAM_DATA_WIDTH  read data, valid the cycle after the read access cycle

## Operation
- All SRAM outputs are registered. Idle drive: ce_n=we_n=oe_n=ub_n=lb_n=1; addr and wr_data hold their last value.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP.
- IDLE: req_wr=1 accepts a write (takes priority if req_rd is also 1; the read is dropped). Otherwise req_rd=1 accepts a read. Address, be and wdata are latched on accept.
- Write half skip: a half whose two enables are both 0 generates no SRAM cycle.
  - be[1:0]≠0 → WR_LO; else if be[3:2]≠0 → WR_HI; else (be=0) → IDLE with rsp_valid=1 and no SRAM activity.
- WR_LO drives: ce_n=0, we_n=0, oe_n=1, addr={a,0}, wr_data=wdata[15:0], lb_n=~be[0], ub_n=~be[1]. Next state is WR_HI if be[3:2]≠0, else IDLE with rsp_valid.
- WR_HI drives: addr={a,1}, wr_data=wdata[31:16], lb_n=~be[2], ub_n=~be[3]. Next state IDLE with rsp_valid.
- Reads ignore req_be. All reads fetch both halves with ub_n=lb_n=0, we_n=1, oe_n=0, ce_n=0.
  - RD_LO: addr={a,0} → RD_HI.
  - RD_HI: addr={a,1}; captures lo ← sram_rd_data → RD_CAP.
  - RD_CAP: SRAM controls deasserted; rsp_rdata ← {sram_rd_data, lo}; rsp_valid=1 → IDLE.
- Requests arriving while req_ready=0 are ignored, not queued.
- Address wrap: none is needed. The word address maps directly; word 2^(W-1)-1 uses SRAM half-words 2^W-2 and 2^W-1.

## Timing
- Request sampled at edge E0.
- Full write: SRAM lo cycle E0–E1, hi cycle E1–E2, rsp_valid high E2–E3 (2-cycle latency).
- Half write: one SRAM cycle; rsp_valid after 1 edge.
- be=0 write: rsp_valid after 1 edge.
- Read: lo access E0–E1, hi access E1–E2, data capture at E3; rsp_valid and rsp_rdata valid E3–E4 (3-cycle latency).
- req_ready=1 during the rsp_valid cycle, so back-to-back requests are allowed.
  - Sustained read period: 4 cycles. Sustained full-write period: 3 cycles.
- Reset (asynchronous, any time):
  - state=IDLE; all SRAM controls 1; sram_addr=0, sram_wr_data=0; rsp_valid=0, rsp_rdata=0; req_ready=1.
  - An in-flight access is aborted with no rsp_valid; the aborted write may have updated the lo half only.
- Exactly one rsp_valid pulse per accepted request.

## Test plan
- Write 0xDEADBEEF to word 0x005, be=1111.
  - Required: addr 0x00A/BEEF then 0x00B/DEAD, we_n=0, ub_n=lb_n=0; rsp_valid 2 cycles after accept.
  - Then read 0x005 → rsp_rdata=0xDEADBEEF, 3 cycles after accept.
- Write 0x00AA0000 to word 0x005, be=0100.
  - Required: single SRAM cycle at 0x00B with lb_n=0, ub_n=1; rsp_valid after 1 cycle.
  - Read back → 0xDEAABEEF.
- be=0000 write → no ce_n assertion, rsp_valid after 1 cycle. Read and write asserted together → treated as a write only, one rsp_valid.
- Word 0x1FF write 0x12345678, read back.
  - Required: SRAM addrs 0x3FE/0x3FF; read returns 0x12345678.
- Read pulsed during a busy write → ignored. Two reads issued on consecutive req_ready cycles complete 4 cycles apart, with one rsp_valid each.
- Assert rst in RD_HI.
  - Required: all SRAM controls 1 immediately, rsp_valid never pulses, req_ready=1, rsp_rdata=0.
  - Next read completes normally.

Source files
------------

// File: rtl/sram_bridge.sv
// sram_bridge: 32-bit host port onto a 16-bit synchronous SRAM.
// Each word access becomes a lo-half then hi-half SRAM cycle.
module sram_bridge #(
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int SRAM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_rd,
    input  logic                       req_wr,
    input  logic [SRAM_ADDR_WIDTH-2:0] req_addr,
    input  logic [3:0]                 req_be,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    output logic                       req_ready,
    output logic                       rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       sram_ce_n,
    output logic                       sram_we_n,
    output logic                       sram_oe_n,
    output logic                       sram_ub_n,
    output logic                       sram_lb_n,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data
);

    localparam int WA = SRAM_ADDR_WIDTH - 1;
    localparam int SW = SRAM_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP
    } state_t;

    state_t state_q, state_d;

    logic [WA-1:0]              addr_q, addr_d;
    logic [3:0]                 be_q, be_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [SW-1:0]              lo_q, lo_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       ce_n_q, ce_n_d;
    logic                       we_n_q, we_n_d;
    logic                       oe_n_q, oe_n_d;
    logic                       ub_n_q, ub_n_d;
    logic                       lb_n_q, lb_n_d;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [SW-1:0]              sram_wd_q, sram_wd_d;
    logic                       accept;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; a write wins over a simultaneous read and
    // halves with no byte enables are skipped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_wr) begin
                    if (|req_be[1:0])      state_d = WR_LO;
                    else if (|req_be[3:2]) state_d = WR_HI;
                    else                   state_d = IDLE;
                end else if (req_rd) begin
                    state_d = RD_LO;
                end
            end
            WR_LO:   state_d = (|be_q[3:2]) ? WR_HI : IDLE;
            WR_HI:   state_d = IDLE;
            RD_LO:   state_d = RD_HI;
            RD_HI:   state_d = RD_CAP;
            RD_CAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: latch the request on accept, then precompute the
    // registered SRAM pin values for the state being entered.
    always_comb begin
        accept      = (state_q == IDLE) && (req_wr || req_rd);
        addr_d      = accept ? req_addr  : addr_q;
        be_d        = accept ? req_be    : be_q;
        wdata_d     = accept ? req_wdata : wdata_q;
        lo_d        = (state_q == RD_HI) ? sram_rd_data : lo_q;
        rdata_d     = (state_q == RD_CAP) ? {sram_rd_data, lo_q} : rdata_q;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            IDLE:    rsp_valid_d = req_wr && (req_be == 4'b0000);
            WR_LO:   rsp_valid_d = ~|be_q[3:2];
            WR_HI:   rsp_valid_d = 1'b1;
            RD_CAP:  rsp_valid_d = 1'b1;
            default: rsp_valid_d = 1'b0;
        endcase
        ce_n_d      = 1'b1;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        sram_addr_d = sram_addr_q;
        sram_wd_d   = sram_wd_q;
        unique case (state_d)
            WR_LO: begin
                ce_n_d      = 1'b0;
                we_n_d      = 1'b0;
                lb_n_d      = ~be_d[0];
                ub_n_d      = ~be_d[1];
                sram_addr_d = {addr_d, 1'b0};
                sram_wd_d   = wdata_d[SW-1:0];
            end
            WR_HI: begin
                ce_n_d      = 1'b0;
                we_n_d      = 1'b0;
                lb_n_d      = ~be_d[2];
                ub_n_d      = ~be_d[3];
                sram_addr_d = {addr_d, 1'b1};
                sram_wd_d   = wdata_d[DATA_WIDTH-1:SW];
            end
            RD_LO: begin
                ce_n_d      = 1'b0;
                oe_n_d      = 1'b0;
                lb_n_d      = 1'b0;
                ub_n_d      = 1'b0;
                sram_addr_d = {addr_d, 1'b0};
            end
            RD_HI: begin
                ce_n_d      = 1'b0;
                oe_n_d      = 1'b0;
                lb_n_d      = 1'b0;
                ub_n_d      = 1'b0;
                sram_addr_d = {addr_d, 1'b1};
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    // Datapath and registered SRAM pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            sram_addr_q <= '0;
            sram_wd_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            sram_addr_q <= sram_addr_d;
            sram_wd_q   <= sram_wd_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_we_n    = we_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_ub_n    = ub_n_q;
    assign sram_lb_n    = lb_n_q;
    assign sram_addr    = sram_addr_q;
    assign sram_wr_data = sram_wd_q;

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed scenarios against sram_bridge with a
// behavioural 16-bit synchronous SRAM attached to its pins.
module tb_sram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic [9:0]  sram_addr;
    logic [15:0] sram_wr_data;
    logic [15:0] sram_rd_data = '0;

    logic [15:0] mem [0:1023];

    int n_cmp = 0;
    int n_bad = 0;
    int rsp_cnt = 0;
    int ce_cnt = 0;
    int oe_cnt = 0;

    sram_bridge dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .sram_addr(sram_addr), .sram_wr_data(sram_wr_data),
        .sram_rd_data(sram_rd_data)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model with byte lanes.
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_wr_data[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] <= sram_wr_data[15:8];
        end
        if (!sram_ce_n && !sram_oe_n && sram_we_n)
            sram_rd_data <= mem[sram_addr];
    end

    // Activity counters sampled on the rising edge.
    always @(posedge clk) begin
        if (rsp_valid)  rsp_cnt <= rsp_cnt + 1;
        if (!sram_ce_n) ce_cnt  <= ce_cnt + 1;
        if (!sram_oe_n) oe_cnt  <= oe_cnt + 1;
    end

    task automatic run_read(input logic [8:0] a, input logic [31:0] exp,
                            input string nm);
        @(negedge clk);
        req_rd = 1'b1; req_addr = a;
        @(negedge clk);
        req_rd = 1'b0;
        n_cmp++;
        if (sram_oe_n !== 1'b0 || sram_ce_n !== 1'b0 || sram_we_n !== 1'b1
            || sram_addr !== {a, 1'b0}) begin
            n_bad++;
            $display("FAIL %s lo access: oe_n=%b ce_n=%b we_n=%b addr=%h want 0 0 1 %h",
                     nm, sram_oe_n, sram_ce_n, sram_we_n, sram_addr, {a, 1'b0});
        end
        @(negedge clk);
        n_cmp++;
        if (sram_addr !== {a, 1'b1} || sram_oe_n !== 1'b0) begin
            n_bad++;
            $display("FAIL %s hi access: addr=%h oe_n=%b want %h 0",
                     nm, sram_addr, sram_oe_n, {a, 1'b1});
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || sram_ce_n !== 1'b1) begin
            n_bad++;
            $display("FAIL %s cap cycle: rsp_valid=%b ce_n=%b want 0 1",
                     nm, rsp_valid, sram_ce_n);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s rsp: valid=%b rdata=%h ready=%b want 1 %h 1",
                     nm, rsp_valid, rsp_rdata, req_ready, exp);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if ({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n} !== 5'b11111
            || sram_addr !== 10'h0 || sram_wr_data !== 16'h0
            || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: ctl=%b addr=%h wd=%h v=%b rd=%h rdy=%b want 11111 0 0 0 0 1",
                     {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n},
                     sram_addr, sram_wr_data, rsp_valid, rsp_rdata, req_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_write;
        @(negedge clk);
        req_wr = 1'b1; req_addr = 9'h005; req_be = 4'hF; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_wr = 1'b0;
        n_cmp++;
        if (sram_ce_n !== 1'b0 || sram_we_n !== 1'b0 || sram_oe_n !== 1'b1
            || sram_addr !== 10'h00A || sram_wr_data !== 16'hBEEF
            || sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_full lo: ce=%b we=%b oe=%b addr=%h wd=%h ub=%b lb=%b rdy=%b want 0 0 1 00a beef 0 0 0",
                     sram_ce_n, sram_we_n, sram_oe_n, sram_addr, sram_wr_data,
                     sram_ub_n, sram_lb_n, req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (sram_we_n !== 1'b0 || sram_addr !== 10'h00B || sram_wr_data !== 16'hDEAD
            || sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_full hi: we=%b addr=%h wd=%h ub=%b lb=%b v=%b want 0 00b dead 0 0 0",
                     sram_we_n, sram_addr, sram_wr_data, sram_ub_n, sram_lb_n, rsp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || sram_ce_n !== 1'b1 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_full rsp: v=%b ce=%b rdy=%b want 1 1 1",
                     rsp_valid, sram_ce_n, req_ready);
        end
        run_read(9'h005, 32'hDEADBEEF, "rd_full");
    endtask

    task automatic test_half_write;
        @(negedge clk);
        req_wr = 1'b1; req_addr = 9'h005; req_be = 4'b0100; req_wdata = 32'h00AA0000;
        @(negedge clk);
        req_wr = 1'b0;
        n_cmp++;
        if (sram_ce_n !== 1'b0 || sram_we_n !== 1'b0 || sram_addr !== 10'h00B
            || sram_lb_n !== 1'b0 || sram_ub_n !== 1'b1 || sram_wr_data !== 16'h00AA) begin
            n_bad++;
            $display("FAIL wr_half cyc: ce=%b we=%b addr=%h lb=%b ub=%b wd=%h want 0 0 00b 0 1 00aa",
                     sram_ce_n, sram_we_n, sram_addr, sram_lb_n, sram_ub_n, sram_wr_data);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || sram_ce_n !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_half rsp: v=%b ce=%b want 1 1", rsp_valid, sram_ce_n);
        end
        run_read(9'h005, 32'hDEAABEEF, "rd_half");
    endtask

    task automatic test_be_zero;
        int ce0, rsp0;
        @(negedge clk);
        ce0 = ce_cnt; rsp0 = rsp_cnt;
        req_wr = 1'b1; req_addr = 9'h005; req_be = 4'b0000; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        req_wr = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || sram_ce_n !== 1'b1 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL be0 rsp: v=%b ce=%b rdy=%b want 1 1 1",
                     rsp_valid, sram_ce_n, req_ready);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ce_cnt - ce0 !== 0 || rsp_cnt - rsp0 !== 1) begin
            n_bad++;
            $display("FAIL be0 activity: ce_cycles=%0d rsp=%0d want 0 1",
                     ce_cnt - ce0, rsp_cnt - rsp0);
        end
        run_read(9'h005, 32'hDEAABEEF, "rd_be0");
    endtask

    task automatic test_rd_wr_both;
        int rsp0, oe0;
        @(negedge clk);
        rsp0 = rsp_cnt; oe0 = oe_cnt;
        req_wr = 1'b1; req_rd = 1'b1; req_addr = 9'h007;
        req_be = 4'hF; req_wdata = 32'h11223344;
        @(negedge clk);
        req_wr = 1'b0; req_rd = 1'b0;
        n_cmp++;
        if (sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 || sram_addr !== 10'h00E) begin
            n_bad++;
            $display("FAIL both kind: we=%b oe=%b addr=%h want 0 1 00e",
                     sram_we_n, sram_oe_n, sram_addr);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (rsp_cnt - rsp0 !== 1 || oe_cnt - oe0 !== 0) begin
            n_bad++;
            $display("FAIL both count: rsp=%0d oe_cycles=%0d want 1 0",
                     rsp_cnt - rsp0, oe_cnt - oe0);
        end
        run_read(9'h007, 32'h11223344, "rd_both");
    endtask

    task automatic test_top_word;
        @(negedge clk);
        req_wr = 1'b1; req_addr = 9'h1FF; req_be = 4'hF; req_wdata = 32'h12345678;
        @(negedge clk);
        req_wr = 1'b0;
        n_cmp++;
        if (sram_addr !== 10'h3FE || sram_wr_data !== 16'h5678) begin
            n_bad++;
            $display("FAIL top lo: addr=%h wd=%h want 3fe 5678", sram_addr, sram_wr_data);
        end
        @(negedge clk);
        n_cmp++;
        if (sram_addr !== 10'h3FF || sram_wr_data !== 16'h1234) begin
            n_bad++;
            $display("FAIL top hi: addr=%h wd=%h want 3ff 1234", sram_addr, sram_wr_data);
        end
        @(negedge clk);
        run_read(9'h1FF, 32'h12345678, "rd_top");
    endtask

    task automatic test_busy_ignore;
        int rsp0, oe0;
        @(negedge clk);
        rsp0 = rsp_cnt; oe0 = oe_cnt;
        req_wr = 1'b1; req_addr = 9'h002; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_wr = 1'b0; req_rd = 1'b1; req_addr = 9'h005;
        @(negedge clk);
        req_rd = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (rsp_cnt - rsp0 !== 1 || oe_cnt - oe0 !== 0) begin
            n_bad++;
            $display("FAIL busy ignore: rsp=%0d oe_cycles=%0d want 1 0",
                     rsp_cnt - rsp0, oe_cnt - oe0);
        end
        run_read(9'h002, 32'hCAFEF00D, "rd_busy");
    endtask

    task automatic test_back_to_back;
        int rsp0;
        @(negedge clk);
        rsp0 = rsp_cnt;
        req_rd = 1'b1; req_addr = 9'h005;
        @(negedge clk);
        req_rd = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAABEEF || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b first: v=%b rd=%h rdy=%b want 1 deaabeef 1",
                     rsp_valid, rsp_rdata, req_ready);
        end
        req_rd = 1'b1; req_addr = 9'h1FF;
        @(negedge clk);
        req_rd = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || sram_oe_n !== 1'b0 || sram_addr !== 10'h3FE) begin
            n_bad++;
            $display("FAIL b2b second start: v=%b oe=%b addr=%h want 0 0 3fe",
                     rsp_valid, sram_oe_n, sram_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b early: v=%b want 0", rsp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL b2b second: v=%b rd=%h want 1 12345678", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_cnt - rsp0 !== 2) begin
            n_bad++;
            $display("FAIL b2b count: rsp=%0d want 2", rsp_cnt - rsp0);
        end
    endtask

    task automatic test_reset_rd_hi;
        int rsp0;
        @(negedge clk);
        req_rd = 1'b1; req_addr = 9'h007;
        @(negedge clk);
        req_rd = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sram_addr !== 10'h00F || sram_oe_n !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_hi pre: addr=%h oe=%b want 00f 0", sram_addr, sram_oe_n);
        end
        rsp0 = rsp_cnt;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n} !== 5'b11111
            || rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_hi abort: ctl=%b v=%b rdy=%b rd=%h want 11111 0 1 0",
                     {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n},
                     rsp_valid, req_ready, rsp_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rsp_cnt - rsp0 !== 0) begin
            n_bad++;
            $display("FAIL rst_hi pulse: rsp=%0d want 0", rsp_cnt - rsp0);
        end
        run_read(9'h007, 32'h11223344, "rd_after_rst");
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_half_write();
        test_be_zero();
        test_rd_wr_both();
        test_top_word();
        test_busy_ignore();
        test_back_to_back();
        test_reset_rd_hi();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
